// File: rtl/wave_reader_pkg.sv
// wave_reader_pkg: shared types and default widths for the waveform reader.
//   state_t        - playback FSM states (IDLE, FETCH, OUT, WAIT)
//   ADDR_W_DEF     - default waveform table address width (32 entries)
//   DATA_W_DEF     - default waveform table data width
//   DIV_W_DEF      - default per-sample cycle divider width
package wave_reader_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 4;
  localparam int DIV_W_DEF  = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_OUT   = 2'd2,
    ST_WAIT  = 2'd3
  } state_t;

endpackage

// File: rtl/wave_reader_if.sv
// wave_reader_if: control, waveform-table and sample-stream signals of the
// waveform reader, bundled with direction views.
//   slave  modport - the reader itself (drives rom_addr/sample/sample_valid/busy)
//   master modport - the surrounding logic (drives start/stop/note_div/rom_data/sample_ready)
// Optional: WAVE_READER_ONESHOT_EN adds the one-cycle done pulse.
interface wave_reader_if
  import wave_reader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DIV_W  = DIV_W_DEF
);
  logic              start;
  logic              stop;
  logic [DIV_W-1:0]  note_div;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic [DATA_W-1:0] sample;
  logic              sample_valid;
  logic              sample_ready;
  logic              busy;
`ifdef WAVE_READER_ONESHOT_EN
  logic              done;
`endif

  modport slave (
    input  start, stop, note_div, rom_data, sample_ready,
`ifdef WAVE_READER_ONESHOT_EN
    output done,
`endif
    output rom_addr, sample, sample_valid, busy
  );

  modport master (
    output start, stop, note_div, rom_data, sample_ready,
`ifdef WAVE_READER_ONESHOT_EN
    input  done,
`endif
    input  rom_addr, sample, sample_valid, busy
  );
endinterface

// File: rtl/wave_div_counter.sv
// wave_div_counter: down-counter that paces sample fetches.
//   clk, rst  - clock, synchronous active-high reset (count -> 0)
//   load      - load load_val (wins over dec)
//   dec       - decrement by one, saturating at zero
//   count     - current count
//   zero      - count is zero
module wave_div_counter #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             dec,
  input  logic [DIV_W-1:0] load_val,
  output logic [DIV_W-1:0] count,
  output logic             zero
);
  logic [DIV_W-1:0] count_r;

  // count register: load, saturating decrement, or hold
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= {DIV_W{1'b0}};
    end else if (load) begin
      count_r <= load_val;
    end else if (dec && (count_r != {DIV_W{1'b0}})) begin
      count_r <= count_r - {{(DIV_W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;
  assign zero  = (count_r == {DIV_W{1'b0}});
endmodule

// File: rtl/wave_reader.sv
// wave_reader: plays a waveform table out as a valid/ready sample stream,
// fetching one entry every div_q cycles after each accepted sample.
//   clk, rst - clock, synchronous active-high reset
//   bus      - wave_reader_if.slave: start/stop/note_div control, rom_addr/rom_data
//              table port (table registers data on the falling edge),
//              sample/sample_valid/sample_ready stream, busy status
// Optional: WAVE_READER_ONESHOT_EN plays the table once and pulses bus.done
// instead of wrapping from the last address back to 0.
module wave_reader
  import wave_reader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DIV_W  = DIV_W_DEF
) (
  input  logic clk,
  input  logic rst,
  wave_reader_if.slave bus
);
  state_t            state_r, state_nx;
  logic [ADDR_W-1:0] rom_addr_r;
  logic [DATA_W-1:0] sample_r;
  logic [DIV_W-1:0]  div_q_r;
  logic              valid_r, valid_nx;
  logic              busy_r, busy_nx;
  logic              done_r, done_nx;
  logic              cnt_load_s, cnt_dec_s, cnt_zero_s;
  logic [DIV_W-1:0]  cnt_s;

  // A divider of 0 would mean "no wait"; treat it as the minimum of 1.
  function automatic logic [DIV_W-1:0] div_clamp(input logic [DIV_W-1:0] d);
    return (d == {DIV_W{1'b0}}) ? {{(DIV_W-1){1'b0}}, 1'b1} : d;
  endfunction

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // next-state logic; stop overrides every other transition
  always_comb begin
    state_nx = state_r;
    case (state_r)
      ST_IDLE:  state_nx = bus.start ? ST_FETCH : ST_IDLE;
      ST_FETCH: state_nx = ST_OUT;
      ST_OUT: begin
        if (bus.sample_ready) begin
`ifdef WAVE_READER_ONESHOT_EN
          state_nx = (rom_addr_r == {ADDR_W{1'b1}}) ? ST_IDLE : ST_WAIT;
`else
          state_nx = ST_WAIT;
`endif
        end else begin
          state_nx = ST_OUT;
        end
      end
      ST_WAIT:  state_nx = cnt_zero_s ? ST_FETCH : ST_WAIT;
      default:  state_nx = ST_IDLE;
    endcase
    if (bus.stop) begin
      state_nx = ST_IDLE;
    end else begin
      state_nx = state_nx;
    end
  end

  // output decode from the upcoming state so the flags are registered
  always_comb begin
    valid_nx = (state_nx == ST_OUT);
    busy_nx  = (state_nx != ST_IDLE);
    // done only marks natural completion of the last sample, never a stop
    done_nx  = (state_r == ST_OUT) && (state_nx == ST_IDLE) && !bus.stop;
  end

  // counter is loaded on the sample handshake and runs down through WAIT
  assign cnt_load_s = (state_r == ST_OUT) && (state_nx == ST_WAIT);
  assign cnt_dec_s  = (state_r == ST_WAIT);

  wave_div_counter #(.DIV_W(DIV_W)) u_div (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load_s),
    .dec      (cnt_dec_s),
    .load_val (div_q_r - {{(DIV_W-1){1'b0}}, 1'b1}),
    .count    (cnt_s),
    .zero     (cnt_zero_s)
  );

  // datapath: divider latch, table address, captured sample, output flags
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q_r    <= {{(DIV_W-1){1'b0}}, 1'b1};
      rom_addr_r <= {ADDR_W{1'b0}};
      sample_r   <= {DATA_W{1'b0}};
      valid_r    <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      valid_r <= valid_nx;
      busy_r  <= busy_nx;
      done_r  <= done_nx;
      if ((state_r == ST_IDLE) && (state_nx == ST_FETCH)) begin
        div_q_r    <= div_clamp(bus.note_div);
        rom_addr_r <= {ADDR_W{1'b0}};
      end else if ((state_r == ST_WAIT) && (state_nx == ST_FETCH)) begin
        // natural modulo-2^ADDR_W wrap
        rom_addr_r <= rom_addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
      end else begin
        rom_addr_r <= rom_addr_r;
      end
      // rom_data was registered by the table on the falling edge inside FETCH
      if ((state_r == ST_FETCH) && (state_nx == ST_OUT)) begin
        sample_r <= bus.rom_data;
      end else begin
        sample_r <= sample_r;
      end
    end
  end

  assign bus.rom_addr     = rom_addr_r;
  assign bus.sample       = sample_r;
  assign bus.sample_valid = valid_r;
  assign bus.busy         = busy_r;
`ifdef WAVE_READER_ONESHOT_EN
  assign bus.done         = done_r;
`endif
endmodule

// File: tb/tb_wave_reader.sv
// tb_wave_reader: directed bench for wave_reader against a 0..31 ramp table
// (DATA_W widened to 5 so each ramp entry equals its address).
// Covers WAVE_READER_ONESHOT_EN when that macro is defined.
module tb_wave_reader;
  localparam int AW = 5;
  localparam int DW = 5;
  localparam int VW = 16;

  logic clk;
  logic rst;
  int   vectors;
  int   errors;
  int   n;

  wave_reader_if #(.ADDR_W(AW), .DATA_W(DW), .DIV_W(VW)) bus ();

  wave_reader #(.ADDR_W(AW), .DATA_W(DW), .DIV_W(VW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ramp table, registered on the falling edge
  always @(negedge clk) bus.rom_data <= bus.rom_addr;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ticks until sample_valid is seen (bounded); n = cycles taken
  task automatic next_valid(output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (bus.sample_valid !== 1'b1 && cnt < 40);
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.sample_ready = 1'b0;
    bus.note_div = 16'd3;
    tick();
    tick();
    chk("rst_valid", bus.sample_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_sample", bus.sample, 0);
    chk("rst_addr", bus.rom_addr, 0);
    rst = 1'b0;
    tick();
    chk("idle_busy", bus.busy, 0);

    // playback with note_div=3: 5-cycle sample period
    bus.sample_ready = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("start_busy", bus.busy, 1);
    chk("start_addr", bus.rom_addr, 0);
    next_valid(n);
    chk("first_latency", n, 1);
    chk("sample0", bus.sample, 0);
    for (int k = 1; k <= 4; k++) begin
      next_valid(n);
      chk("period_div3", n, 5);
      chk("sample_ramp", bus.sample, k);
    end

    // backpressure at address 4
    bus.sample_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_sample", bus.sample, 4);
      chk("hold_addr", bus.rom_addr, 4);
      chk("hold_valid", bus.sample_valid, 1);
    end
    bus.sample_ready = 1'b1;
    for (int k = 5; k <= 9; k++) begin
      next_valid(n);
      chk("period_after_hold", n, 5);
      chk("sample_after_hold", bus.sample, k);
    end

    // stop coincident with handshake at address 9
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    chk("stop_valid", bus.sample_valid, 0);
    chk("stop_busy", bus.busy, 0);
    tick();
    chk("stop_idle_valid", bus.sample_valid, 0);

    // restart with note_div=1: replays from 0, 3-cycle period
    bus.note_div = 16'd1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    next_valid(n);
    chk("restart_latency", n, 1);
    chk("restart_sample0", bus.sample, 0);
`ifdef WAVE_READER_ONESHOT_EN
    for (int k = 1; k <= 31; k++) begin
      next_valid(n);
      chk("os_period", n, 3);
      chk("os_sample", bus.sample, k);
    end
    chk("os_done_before", bus.done, 0);
    tick();
    chk("os_done_pulse", bus.done, 1);
    chk("os_busy_end", bus.busy, 0);
    chk("os_valid_end", bus.sample_valid, 0);
    tick();
    chk("os_done_clear", bus.done, 0);
    repeat (6) tick();
    chk("os_no_more_valid", bus.sample_valid, 0);
    chk("os_idle_busy", bus.busy, 0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    next_valid(n);
    chk("os_restart_latency", n, 1);
    chk("os_restart_sample", bus.sample, 0);
`else
    for (int k = 1; k <= 39; k++) begin
      if (k == 10) begin
        // start and note_div changes mid-run must be ignored
        bus.start = 1'b1;
        bus.note_div = 16'd7;
      end
      next_valid(n);
      bus.start = 1'b0;
      chk("loop_period", n, 3);
      chk("loop_sample", bus.sample, k % 32);
      chk("loop_busy", bus.busy, 1);
    end
`endif

    // note_div=0 clamps to 1, then reset mid-WAIT
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    bus.note_div = 16'd0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    next_valid(n);
    chk("div0_latency", n, 1);
    chk("div0_sample0", bus.sample, 0);
    next_valid(n);
    chk("div0_period", n, 3);
    chk("div0_sample1", bus.sample, 1);
    tick();
    chk("wait_busy", bus.busy, 1);
    chk("wait_valid", bus.sample_valid, 0);
    rst = 1'b1;
    tick();
    chk("rstw_valid", bus.sample_valid, 0);
    chk("rstw_busy", bus.busy, 0);
    chk("rstw_sample", bus.sample, 0);
    chk("rstw_addr", bus.rom_addr, 0);
    rst = 1'b0;
    tick();
    chk("rstw_idle_busy", bus.busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/wave_reader.md
WAVE_READER -- requirements
Module: wave_reader

Interface
REQ-001 Parameter ADDR_W, default 5: waveform table address width (32 entries).
REQ-002 Parameter DATA_W, default 4: waveform table data width.
REQ-003 Parameter DIV_W, default 16: width of the per-sample cycle divider.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 start  in  1  one-cycle request to begin playback; sampled only in IDLE.
REQ-007 stop  in  1  abort playback; return to IDLE on the next edge.
REQ-008 note_div  in  DIV_W  cycles between sample fetches; latched at start.
REQ-009 rom_addr  out  ADDR_W  address driven to the waveform table.
REQ-010 rom_data  in  DATA_W  table output, registered by the table on the falling clock edge.
REQ-011 sample  out  DATA_W  current sample; held stable while sample_valid=1.
REQ-012 sample_valid  out  1  sample available.
REQ-013 sample_ready  in  1  consumer accepts the sample when sample_valid=1 and sample_ready=1.
REQ-014 busy  out  1  high in every state except IDLE.

Function
REQ-015 The FSM SHALL have states IDLE, FETCH, OUT and WAIT.
REQ-016 IDLE->FETCH on start=1; latch div_q=max(note_div,1); rom_addr=0.
REQ-017 FETCH SHALL last exactly one cycle with rom_addr stable; on exit, capture rom_data into sample; go to OUT.
REQ-018 OUT SHALL assert sample_valid; stay until sample_ready=1; on handshake go to WAIT and load the counter with div_q-1.
REQ-019 WAIT SHALL decrement the counter each cycle; at 0, increment rom_addr and enter FETCH. With div_q=1, WAIT lasts 1 cycle.
REQ-020 Address arithmetic SHALL be modulo 2^ADDR_W (31 -> 0 wrap) unless REQ-028 applies.
REQ-021 Minimum handshake-to-next-valid latency SHALL be div_q+1 cycles (WAIT, FETCH).
REQ-022 stop=1 in any state SHALL force IDLE next edge, clearing sample_valid; stop has priority over a simultaneous handshake or start.
REQ-023 start asserted outside IDLE SHALL be ignored; note_div changes outside IDLE SHALL have no effect.
REQ-024 sample and rom_addr SHALL NOT change while sample_valid=1 and sample_ready=0.

Reset
REQ-025 rst=1 SHALL force IDLE, rom_addr=0, sample=0, sample_valid=0, busy=0, counter=0, div_q=1.
REQ-026 rst SHALL override stop, start and handshake in the same cycle, including mid-WAIT or mid-OUT.

Configuration
REQ-027 Macro WAVE_READER_ONESHOT_EN SHALL select one-shot playback.
REQ-028 Defined: after the handshake of the sample at address 2^ADDR_W-1 the FSM SHALL return to IDLE (no wrap), and output done (1 bit) SHALL pulse for one cycle; undefined: playback loops until stop and no done port exists.

Structure
REQ-029 A shared package SHALL hold the FSM state enumeration and default widths (ADDR_W, DATA_W, DIV_W).
REQ-030 The divider counter SHALL be a sub-module wave_div_counter (load, decrement, zero flag); all else stays in wave_reader.

Verification
REQ-031 Reset then start with note_div=3 and sample_ready=1 against the standard 0..31 ramp table -> samples 0,1,2,... with sample_valid spaced 5 cycles apart.
REQ-032 sample_ready held 0 for 10 cycles at address 4 -> sample=4 and rom_addr=4 stable throughout, then 5 follows after handshake.
REQ-033 Loop build, note_div=1, run 40 samples -> sequence 0..31,0..7; busy stays 1.
REQ-034 WAVE_READER_ONESHOT_EN build -> 32 samples 0..31, done pulses once, busy=0, further samples only after a new start.
REQ-035 stop asserted coincident with a handshake at address 9 -> IDLE next cycle, sample_valid=0, next start replays from address 0.
REQ-036 rst asserted during WAIT with note_div=0 latched as 1 -> all outputs per REQ-025 on the following edge.
